serial_word_shifter: RTL and testbench
======================================

# serial_word_shifter

Parallel-to-serial front end for the sequence-detector path. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock onto a single serial line. That line drives the serial input `x` of the downstream Moore pattern detector. Back-to-back words stream gaplessly, so patterns spanning a word boundary remain detectable.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data_in`  input  WIDTH  word to serialize; sampled only on an accepted load.
- `load_valid`  input  1  upstream offers `data_in`.
- `load_ready`  output  1  block can accept a word this cycle.
- `serial_out`  output  1  current serial bit; connects to the detector's `x`.
- `serial_valid`  output  1  `serial_out` carries a word bit this cycle.
- `word_done`  output  1  one-cycle pulse coincident with the last bit of each word.

## Operation
- States: IDLE and SHIFT (2-bit encoding, default arm returns to IDLE).
- Accept is defined as `load_valid && load_ready` at a rising edge.
- `load_ready` is combinational. It is 1 in IDLE. It is 1 in SHIFT only while the last bit is on the line (`bit_cnt == WIDTH-1`). It is 0 otherwise.
- Transitions:
  - IDLE + accept -> SHIFT; load shift register, `bit_cnt` = 0.
  - SHIFT, not last bit -> SHIFT; shift one position, `bit_cnt` + 1.
  - SHIFT, last bit + accept -> SHIFT; reload from `data_in`, `bit_cnt` = 0 (gapless).
  - SHIFT, last bit, no accept -> IDLE.
- `serial_out` is the register bit at the head position: bit WIDTH-1 if `MSB_FIRST`, else bit 0.
- Shift direction: left for MSB-first, right for LSB-first. Vacated positions fill with 0.
- When `serial_valid` = 0, `serial_out` is forced to 0. Idle zeros hold the downstream detector in its start state.
- `bit_cnt` width is $clog2(WIDTH). It never exceeds WIDTH-1, so there is no wrap-around.
- `load_valid` while `load_ready` = 0 is ignored. `data_in` is not sampled, and upstream must hold its word.
- Asserting reset mid-word aborts the word immediately. Remaining bits are discarded, with no partial `word_done`.

## Timing
- Reset values:
  - `serial_out` = 0, `serial_valid` = 0, `word_done` = 0.
  - State = IDLE, so `load_ready` = 1.
  - Shift register = 0, `bit_cnt` = 0.
- Loads presented while reset is high are not accepted.
- Latency: a word accepted at edge k presents its first bit in cycle k+1. Its last bit appears in cycle k+WIDTH.
- `serial_valid` = 1 for exactly WIDTH cycles per word.
- `word_done` = 1 only in cycle k+WIDTH.
- Back-to-back: accept at edge k+WIDTH-1... is not legal. The second word is accepted at the edge ending cycle k+WIDTH (while its last bit is on the line). Its first bit then appears in cycle k+WIDTH+1, so `serial_valid` has no gap.
- Sustained throughput is one bit per clock.
- `serial_out`, `serial_valid`, and `word_done` are registered or derived from registered state only. Only `load_ready` depends combinationally on inputs-free state.

## Structure
- Shared package `serial_pkg` holds:
  - the state encoding constants `ST_IDLE` and `ST_SHIFT`;
  - the default word width constant `SER_WIDTH_DEF` = 8.
- The detector and this block both import `serial_pkg`.
- Natural sub-module: `shift_bit_counter`. It is a `WIDTH`-parameterized up-counter with `clear`/`inc` inputs and a `last` flag (`cnt == WIDTH-1`).
- The top level holds the FSM, the shift register, and the output logic.

## Test plan
- WIDTH=8, MSB_FIRST=1; load 8'hCC at edge 0 -> `serial_out` = 1,1,0,0,1,1,0,0 in cycles 1-8. `serial_valid` is high in cycles 1-8. `word_done` is high in cycle 8 only. Detector `z` fires twice.
- Load 8'h0C, then 8'hC0 held valid -> second word accepted at the last bit of the first. `serial_valid` is high for 16 consecutive cycles. The stream 0000110011000000 appears without a gap.
- Pulse `load_valid` with 8'hFF in cycles 2-6 of a word in flight -> ignored. The in-flight bits are unchanged and `load_ready` = 0 in those cycles.
- Assert reset in cycle 4 of 8'hAA -> outputs 0 the same cycle (asynchronous). No `word_done`. After release, `load_ready` = 1, and a new 8'h33 serializes correctly.
- MSB_FIRST=0, load 8'h03 -> `serial_out` = 1,1,0,0,0,0,0,0.
- WIDTH=4, load 4'hC -> 1,1,0,0 in cycles 1-4. `word_done` in cycle 4. Return to IDLE in cycle 5.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and default word width shared by the serializer and detector.
package serial_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_e;
    localparam int SER_WIDTH_DEF = 8;
endpackage

// File: rtl/shift_bit_counter.sv
// shift_bit_counter: bit position counter within a word; last flags the final bit.
module shift_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d = clear ? '0 : inc ? cnt_q + CW'(1) : cnt_q;
    assign last  = cnt_q == CW'(WIDTH - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/serial_word_shifter.sv
// serial_word_shifter: accepts a word via valid/ready and shifts it out one bit per clock,
// reloading on the last bit so consecutive words stream without a gap.
module serial_word_shifter
    import serial_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_done
);
    localparam int HEAD = MSB_FIRST ? WIDTH - 1 : 0;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             last, shifting, accept, inc;
    assign shifting     = state_q == ST_SHIFT;
    assign load_ready   = !shifting || last;
    assign accept       = load_valid && load_ready;
    assign inc          = shifting && !last;
    assign serial_valid = shifting;
    assign word_done    = shifting && last;
    // Idle forces zeros so the downstream detector stays in its start state.
    assign serial_out   = shifting && sr_q[HEAD];
    shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (reset),
        .clear(!inc),
        .inc  (inc),
        .last (last)
    );
    assign sr_d = accept ? data_in : shifting ? (MSB_FIRST ? sr_q << 1 : sr_q >> 1) : sr_q;
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = accept ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_d = (last && !accept) ? ST_IDLE : ST_SHIFT;
            default:  state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
        end
    end
endmodule

// File: tb/tb_serial_word_shifter.sv
// tb_serial_word_shifter: directed checks of three serializer configurations
// (8-bit MSB-first, 8-bit LSB-first, 4-bit MSB-first).
module tb_serial_word_shifter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] d8 = '0, dl = '0;
    logic [3:0] d4 = '0;
    logic       lv8 = 1'b0, lvl = 1'b0, lv4 = 1'b0;
    logic       lr8, so8, sv8, wd8;
    logic       lrl, sol, svl, wdl;
    logic       lr4, so4, sv4, wd4;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
        .clk(clk), .reset(reset), .data_in(d8), .load_valid(lv8), .load_ready(lr8),
        .serial_out(so8), .serial_valid(sv8), .word_done(wd8));
    serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l8 (
        .clk(clk), .reset(reset), .data_in(dl), .load_valid(lvl), .load_ready(lrl),
        .serial_out(sol), .serial_valid(svl), .word_done(wdl));
    serial_word_shifter #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m4 (
        .clk(clk), .reset(reset), .data_in(d4), .load_valid(lv4), .load_ready(lr4),
        .serial_out(so4), .serial_valid(sv4), .word_done(wd4));

    // Observed tuple {serial_out, serial_valid, word_done, load_ready}
    function automatic logic [3:0] obs(input int sel);
        case (sel)
            0:       return {so8, sv8, wd8, lr8};
            1:       return {sol, svl, wdl, lrl};
            default: return {so4, sv4, wd4, lr4};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed {so,sv,wd,lr}=%b expected %b", tag, got, want);
        end
    endtask

    task automatic offer(input int sel, input logic [7:0] d);
        case (sel)
            0:       begin d8 = d;      lv8 = 1'b1; end
            1:       begin dl = d;      lvl = 1'b1; end
            default: begin d4 = d[3:0]; lv4 = 1'b1; end
        endcase
    endtask

    task automatic drop();
        lv8 = 1'b0;
        lvl = 1'b0;
        lv4 = 1'b0;
    endtask

    // bits holds the expected serial sequence, first bit at position w-1
    task automatic expect_word(input int sel, input string tag, input int w, input logic [7:0] bits);
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            if (i == 0) drop();
            chk($sformatf("%s[%0d]", tag, i), obs(sel), {bits[w-1-i], 1'b1, i == w - 1, i == w - 1});
        end
        @(negedge clk);
        chk({tag, "_idle"}, obs(sel), 4'b0001);
    endtask

    initial begin
        logic [15:0] stream;
        logic [7:0]  word;
        @(negedge clk);
        chk("rst_m8", obs(0), 4'b0001);
        chk("rst_l8", obs(1), 4'b0001);
        chk("rst_m4", obs(2), 4'b0001);
        offer(0, 8'hFF);
        @(negedge clk);
        chk("rst_noload", obs(0), 4'b0001);
        reset = 1'b0;
        drop();
        @(negedge clk);
        chk("post_rst_idle", obs(0), 4'b0001);

        offer(0, 8'hCC);
        expect_word(0, "cc", 8, 8'hCC);

        stream = 16'h0CC0;
        offer(0, 8'h0C);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) d8 = 8'hC0;
            if (i == 8) lv8 = 1'b0;
            chk($sformatf("b2b[%0d]", i), obs(0),
                {stream[15-i], 1'b1, i == 7 || i == 15, i == 7 || i == 15});
        end
        @(negedge clk);
        chk("b2b_idle", obs(0), 4'b0001);

        word = 8'h96;
        offer(0, word);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lv8 = (i >= 1 && i <= 5);
            if (i == 1) d8 = 8'hFF;
            chk($sformatf("ign[%0d]", i), obs(0), {word[7-i], 1'b1, i == 7, i == 7});
        end
        drop();
        @(negedge clk);
        chk("ign_idle", obs(0), 4'b0001);

        word = 8'hAA;
        offer(0, word);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) drop();
            chk($sformatf("aa[%0d]", i), obs(0), {word[7-i], 1'b1, 1'b0, 1'b0});
        end
        reset = 1'b1;
        #1;
        chk("abort_async", obs(0), 4'b0001);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_held", obs(0), 4'b0001);
        @(negedge clk);
        chk("abort_nodone", obs(0), 4'b0001);
        offer(0, 8'h33);
        expect_word(0, "w33", 8, 8'h33);

        offer(1, 8'h03);
        expect_word(1, "lsb03", 8, 8'hC0);

        offer(2, 8'h0C);
        expect_word(2, "w4c", 4, 8'h0C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
